// File: rtl/bin_magnitude_accumulator.sv
// bin_magnitude_accumulator
//   Leaky per-bin energy integrator. Each accepted beat adds its scaled
//   magnitude to acc[bin] and removes acc >> DECAY_SHIFT. A single-cycle
//   dumpReq drains the update pipeline and then streams every bin in order
//   over a valid/ready handshake.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   inMagnitude/inBin magnitude beat and its bin index
//   inValid/inReady   input handshake (inReady high only while idle)
//   dumpReq           single-cycle request to stream out all bins
//   outValue/outBin   streamed accumulator value and its bin index
//   outValid/outReady output handshake, outLast marks bin NUM_BINS-1
//   errBin            sticky: a beat with inBin >= NUM_BINS was received
//
// Optional feature macro: BIN_ACCUM_CLEAR_ON_READ_EN
//   When defined, each bin is cleared in the cycle its dump beat handshakes.
module bin_magnitude_accumulator #(
    parameter int NUM_BINS    = 24,
    parameter int BIN_W       = 5,
    parameter int MAG_W       = 32,
    parameter int ACC_W       = 32,
    parameter int INPUT_SHIFT = 4,
    parameter int DECAY_SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MAG_W-1:0] inMagnitude,
    input  logic [BIN_W-1:0] inBin,
    input  logic             inValid,
    output logic             inReady,
    input  logic             dumpReq,
    output logic [ACC_W-1:0] outValue,
    output logic [BIN_W-1:0] outBin,
    output logic             outValid,
    output logic             outLast,
    input  logic             outReady,
    output logic             errBin
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2
    } state_t;

    localparam logic [BIN_W:0]   BIN_LIMIT = (BIN_W+1)'(NUM_BINS);
    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(NUM_BINS - 1);

    // Leak-and-add with saturation; the extra top bit catches overflow.
    function automatic logic [ACC_W-1:0] leak_update(
        input logic [ACC_W-1:0] acc,
        input logic [ACC_W-1:0] scaled
    );
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} - {1'b0, (acc >> DECAY_SHIFT)} + {1'b0, scaled};
        if (sum[ACC_W]) begin
            leak_update = {ACC_W{1'b1}};
        end else begin
            leak_update = sum[ACC_W-1:0];
        end
    endfunction

    state_t           state_r, state_s;
    logic [BIN_W-1:0] cnt_r, cnt_s;
    logic [ACC_W-1:0] acc_r [NUM_BINS];

    logic             s1_valid_r;
    logic             s1_in_range_r;
    logic [BIN_W-1:0] s1_bin_r;
    logic [ACC_W-1:0] s1_scaled_r;
    logic [ACC_W-1:0] s1_acc_r;

    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [ACC_W-1:0] out_value_r;
    logic             err_r;

    logic             accept_s;
    logic             in_range_s;
    logic             handshake_s;
    logic [ACC_W-1:0] rd_value_s;
    logic [ACC_W-1:0] new_value_s;

    assign accept_s    = inValid && in_ready_r;
    assign in_range_s  = ({1'b0, inBin} < BIN_LIMIT);
    assign handshake_s = out_valid_r && outReady;

    // Stage-2 result and the operand read for the beat being accepted. The
    // beat in stage 1 is written at the same edge the new beat is captured,
    // so a same-bin follower must take the fresh result instead of the array.
    always_comb begin
        new_value_s = leak_update(s1_acc_r, s1_scaled_r);
        rd_value_s  = {ACC_W{1'b0}};
        if (in_range_s) begin
            if (s1_valid_r && s1_in_range_r && (s1_bin_r == inBin)) begin
                rd_value_s = new_value_s;
            end else begin
                rd_value_s = acc_r[inBin];
            end
        end else begin
            rd_value_s = {ACC_W{1'b0}};
        end
    end

    // Stage 1: capture bin, scaled magnitude and current accumulator value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r    <= 1'b0;
            s1_in_range_r <= 1'b0;
            s1_bin_r      <= {BIN_W{1'b0}};
            s1_scaled_r   <= {ACC_W{1'b0}};
            s1_acc_r      <= {ACC_W{1'b0}};
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_in_range_r <= in_range_s;
                s1_bin_r      <= inBin;
                s1_scaled_r   <= ACC_W'(inMagnitude >> INPUT_SHIFT);
                s1_acc_r      <= rd_value_s;
            end
        end
    end

    // Accumulator array: stage-2 write-back and optional clear-on-read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else begin
            if (s1_valid_r && s1_in_range_r) begin
                acc_r[s1_bin_r] <= new_value_s;
            end
`ifdef BIN_ACCUM_CLEAR_ON_READ_EN
            if (handshake_s) begin
                acc_r[cnt_r] <= {ACC_W{1'b0}};
            end
`endif
        end
    end

    // Sticky out-of-range flag, set when such a beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (accept_s && !in_range_s) begin
            err_r <= 1'b1;
        end
    end

    // FSM state and dump counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {BIN_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // FSM next state; DRAIN leaves once the stage-1 beat has been written.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (dumpReq) begin
                    state_s = DRAIN;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (!s1_valid_r) begin
                    state_s = DUMP;
                    cnt_s   = {BIN_W{1'b0}};
                end else begin
                    state_s = DRAIN;
                end
            end
            DUMP: begin
                if (handshake_s) begin
                    if (cnt_r == LAST_BIN) begin
                        state_s = IDLE;
                        cnt_s   = {BIN_W{1'b0}};
                    end else begin
                        cnt_s   = cnt_r + {{(BIN_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {BIN_W{1'b0}};
            end
        endcase
    end

    // Registered handshake outputs derived from the next state, so they are
    // aligned with state_r and hold while outReady is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_value_r <= {ACC_W{1'b0}};
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DUMP);
            out_last_r  <= (state_s == DUMP) && (cnt_s == LAST_BIN);
            if (state_s == DUMP) begin
                out_value_r <= acc_r[cnt_s];
            end
        end
    end

    assign inReady  = in_ready_r;
    assign outValid = out_valid_r;
    assign outLast  = out_last_r;
    assign outValue = out_value_r;
    assign outBin   = cnt_r;
    assign errBin   = err_r;

endmodule

// File: tb/tb_bin_magnitude_accumulator.sv
// Directed testbench for bin_magnitude_accumulator (default parameters).
// Expected bin energies are hand-computed and kept in exp_acc.
module tb_bin_magnitude_accumulator;

    localparam int NUM_BINS = 24;
    localparam int BIN_W    = 5;
    localparam int MAG_W    = 32;
    localparam int ACC_W    = 32;
`ifdef BIN_ACCUM_CLEAR_ON_READ_EN
    localparam bit CLEAR_MODE = 1'b1;
`else
    localparam bit CLEAR_MODE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [MAG_W-1:0] inMagnitude = 32'h0;
    logic [BIN_W-1:0] inBin = 5'd0;
    logic             inValid = 1'b0;
    logic             inReady;
    logic             dumpReq = 1'b0;
    logic [ACC_W-1:0] outValue;
    logic [BIN_W-1:0] outBin;
    logic             outValid;
    logic             outLast;
    logic             outReady = 1'b1;
    logic             errBin;

    int               vec_cnt = 0;
    int               err_cnt = 0;
    logic [ACC_W-1:0] exp_acc [NUM_BINS];

    bin_magnitude_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .inMagnitude (inMagnitude),
        .inBin       (inBin),
        .inValid     (inValid),
        .inReady     (inReady),
        .dumpReq     (dumpReq),
        .outValue    (outValue),
        .outBin      (outBin),
        .outValid    (outValid),
        .outLast     (outLast),
        .outReady    (outReady),
        .errBin      (errBin)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_expected();
        for (int i = 0; i < NUM_BINS; i++) begin
            exp_acc[i] = 32'h0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; inValid = 1'b0; dumpReq = 1'b0; outReady = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_expected();
    endtask

    // Called and returns at a falling edge; one beat per call.
    task automatic send_beat(input int bin, input logic [31:0] mag);
        inValid     = 1'b1;
        inBin       = BIN_W'(bin);
        inMagnitude = mag;
        check_val("in_ready_idle", 32'(inReady), 32'd1);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    // Request and consume a full dump. bp_at: bin at which outReady drops for
    // 5 cycles; abort_at: bin at which rst is pulsed; beat_*: a beat driven
    // together with dumpReq.
    task automatic do_dump(input int bp_at, input int abort_at,
                           input bit beat_en, input int beat_bin, input logic [31:0] beat_mag);
        int waited;
        dumpReq = 1'b1;
        if (beat_en) begin
            inValid     = 1'b1;
            inBin       = BIN_W'(beat_bin);
            inMagnitude = beat_mag;
            check_val("in_ready_with_req", 32'(inReady), 32'd1);
        end
        @(negedge clk);
        dumpReq = 1'b0;
        inValid = 1'b0;
        waited  = 0;
        while (!outValid && waited < 8) begin
            check_val("in_ready_drain", 32'(inReady), 32'd0);
            @(negedge clk);
            waited++;
        end
        check_val("dump_started", 32'(outValid), 32'd1);
        if (!outValid) return;
        for (int i = 0; i < NUM_BINS; i++) begin
            check_val($sformatf("bin%0d_valid", i), 32'(outValid), 32'd1);
            check_val($sformatf("bin%0d_index", i), 32'(outBin), 32'(i));
            check_val($sformatf("bin%0d_value", i), outValue, exp_acc[i]);
            check_val($sformatf("bin%0d_last", i), 32'(outLast), 32'(i == NUM_BINS - 1));
            check_val($sformatf("bin%0d_in_ready", i), 32'(inReady), 32'd0);
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_val("abort_out_valid", 32'(outValid), 32'd0);
                check_val("abort_out_last", 32'(outLast), 32'd0);
                check_val("abort_err_bin", 32'(errBin), 32'd0);
                check_val("abort_in_ready", 32'(inReady), 32'd1);
                clear_expected();
                return;
            end
            if (i == bp_at) begin
                outReady = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_val("stall_valid", 32'(outValid), 32'd1);
                    check_val("stall_index", 32'(outBin), 32'(i));
                    check_val("stall_value", outValue, exp_acc[i]);
                    check_val("stall_last", 32'(outLast), 32'(i == NUM_BINS - 1));
                    check_val("stall_in_ready", 32'(inReady), 32'd0);
                end
                outReady = 1'b1;
            end
            @(negedge clk);
        end
        check_val("dump_end_valid", 32'(outValid), 32'd0);
        check_val("dump_end_in_ready", 32'(inReady), 32'd1);
        if (CLEAR_MODE) clear_expected();
    endtask

    initial begin
        clear_expected();
        do_reset();

        // Reset state
        check_val("rst_in_ready", 32'(inReady), 32'd1);
        check_val("rst_out_valid", 32'(outValid), 32'd0);
        check_val("rst_out_last", 32'(outLast), 32'd0);
        check_val("rst_out_value", outValue, 32'h0);
        check_val("rst_out_bin", 32'(outBin), 32'd0);
        check_val("rst_err_bin", 32'(errBin), 32'd0);

        // Single beat: 0x100 >> 4 = 0x10
        send_beat(3, 32'h100);
        exp_acc[3] = 32'h10;
        check_val("single_err_bin", 32'(errBin), 32'd0);
        do_dump(-1, -1, 1'b0, 0, 32'h0);

        // Back-to-back same bin: 0x10, then 0x10 - 0 + 0x10
        do_reset();
        send_beat(5, 32'h100);
        send_beat(5, 32'h100);
        exp_acc[5] = 32'h20;
        do_dump(-1, -1, 1'b0, 0, 32'h0);

        // Decay: 0x1000 -> 0x1000-0x40 = 0xFC0 -> 0xFC0-0x3F = 0xF81
        do_reset();
        send_beat(7, 32'h0001_0000);
        send_beat(7, 32'h0);
        exp_acc[7] = 32'hFC0;
        do_dump(-1, -1, 1'b0, 0, 32'h0);
        send_beat(7, 32'h0);
        if (CLEAR_MODE) exp_acc[7] = 32'h0;
        else            exp_acc[7] = 32'hF81;
        do_dump(-1, -1, 1'b0, 0, 32'h0);

        // Saturation, then holding at full scale
        do_reset();
        repeat (200) send_beat(0, 32'hFFFF_FFFF);
        exp_acc[0] = 32'hFFFF_FFFF;
        do_dump(-1, -1, 1'b0, 0, 32'h0);
        repeat (200) send_beat(0, 32'hFFFF_FFFF);
        exp_acc[0] = 32'hFFFF_FFFF;
        do_dump(-1, -1, 1'b0, 0, 32'h0);

        // dumpReq with a concurrent beat (0x40 >> 4 = 0x4), backpressure at bin 4
        do_reset();
        send_beat(9, 32'h250);
        exp_acc[9] = 32'h25;
        exp_acc[2] = 32'h4;
        do_dump(4, -1, 1'b1, 2, 32'h40);
        do_dump(-1, -1, 1'b0, 0, 32'h0);

        // Out-of-range bin: flag set, no accumulator touched, flag sticky
        do_reset();
        send_beat(30, 32'h100);
        check_val("err_set", 32'(errBin), 32'd1);
        do_dump(-1, -1, 1'b0, 0, 32'h0);
        check_val("err_sticky", 32'(errBin), 32'd1);

        // Reset in the middle of a dump at bin 10
        do_reset();
        send_beat(1, 32'h100);
        exp_acc[1] = 32'h10;
        send_beat(31, 32'h100);
        check_val("err_set_31", 32'(errBin), 32'd1);
        do_dump(-1, 10, 1'b0, 0, 32'h0);
        do_dump(-1, -1, 1'b0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
